// File: rtl/dmem_pkg.sv
// Shared types for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int DMEM_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_BAD
    } dmem_op_t;

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable wait-state down-counter; done flags the last wait cycle
// (or an immediate response when loaded with zero).
module dmem_wait_counter
    import dmem_pkg::*;
(
    input  logic                  clock,
    input  logic                  Reset,
    input  logic                  load,
    input  logic [DMEM_CNT_W-1:0] load_val,
    input  logic                  en,
    output logic                  done
);

    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    assign done = load ? (load_val == '0) : (cnt_q == DMEM_CNT_W'(1));

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory with ready/error handshake and programmable wait states.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned word accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t      state_q, state_d;
    dmem_op_t         op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic [31:0]      mem [DEPTH];

    logic cnt_load, cnt_en, cnt_done;
    logic mem_we;
    logic range_err, align_err, acc_bad;

    dmem_wait_counter u_wait_counter (
        .clock    (clock),
        .Reset    (Reset),
        .load     (cnt_load),
        .load_val (DMEM_CNT_W'(WAIT_CYCLES)),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    assign range_err = (addr[31:IDX_W+2] != '0);
`ifdef DMEM_ALIGN_CHECK_EN
    assign align_err = (addr[1:0] != 2'b00);
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr[1:0];
    assign align_err      = 1'b0;
`endif
    assign acc_bad = (mem_rd & mem_wr) | range_err | align_err;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_rd | mem_wr) begin
                    cnt_load = 1'b1;
                    idx_d    = addr[IDX_W+1:2];
                    wdata_d  = wr_data;
                    op_d     = acc_bad ? OP_BAD : (mem_wr ? OP_WR : OP_RD);
                    state_d  = cnt_done ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (cnt_done)
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The access fires on the edge entering RESP; the _d values cover the
        // zero-wait case where acceptance and access share one edge.
        if (state_d == RESP && state_q != RESP) begin
            case (op_d)
                OP_WR:   mem_we    = 1'b1;
                OP_RD:   rd_data_d = mem[idx_d];
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            op_q      <= OP_RD;
            idx_q     <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[idx_d] <= wdata_d;
    end

    assign rd_data   = rd_data_q;
    assign mem_ready = (state_q == RESP);
    assign mem_err   = mem_ready && (op_q == OP_BAD);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: slot 0 runs WAIT_CYCLES=2, slot 1 runs WAIT_CYCLES=0.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        Reset;
    logic        rd_i   [2];
    logic        wr_i   [2];
    logic [31:0] addr_i [2];
    logic [31:0] wd_i   [2];
    logic [31:0] rdat   [2];
    logic        rdy    [2];
    logic        err    [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_cyc [2];

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic        chk;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] mdl   [2][256];
    logic        mdl_v [2][256];
    logic [31:0] exp_rd   [2];
    logic        exp_rd_v [2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_w2 (
        .clock(clock), .Reset(Reset), .mem_rd(rd_i[0]), .mem_wr(wr_i[0]),
        .addr(addr_i[0]), .wr_data(wd_i[0]), .rd_data(rdat[0]),
        .mem_ready(rdy[0]), .mem_err(err[0])
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clock(clock), .Reset(Reset), .mem_rd(rd_i[1]), .mem_wr(wr_i[1]),
        .addr(addr_i[1]), .wr_data(wd_i[1]), .rd_data(rdat[1]),
        .mem_ready(rdy[1]), .mem_err(err[1])
    );

    function automatic int waits(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    // Issue one request on slot s from a negedge with the DUT idle; the request
    // is dropped early at negedge number drop_at (0 = hold until mem_ready).
    task automatic xact(input int s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input int drop_at);
        exp_t e;
        int   n;
        int   idx;
        logic acc_bad;
        acc_bad = (rd && wr) || (a >= 32'h400);
`ifdef DMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) acc_bad = 1'b1;
`endif
        idx = int'(a[9:2]);
        if (acc_bad) begin
            exp_rd[s] = '0; exp_rd_v[s] = 1'b1;
        end else if (wr) begin
            mdl[s][idx] = wd; mdl_v[s][idx] = 1'b1;
        end else begin
            exp_rd[s] = mdl[s][idx]; exp_rd_v[s] = mdl_v[s][idx];
        end
        e.err = acc_bad; e.data = exp_rd[s]; e.chk = exp_rd_v[s];
        sbq.push_back(e);

        rd_i[s] = rd; wr_i[s] = wr; addr_i[s] = a; wd_i[s] = wd;
        n = 0;
        while (n < 20) begin
            @(negedge clock);
            n++;
            if (n == drop_at) begin rd_i[s] = 1'b0; wr_i[s] = 1'b0; end
            if (rdy[s]) break;
        end
        rd_i[s] = 1'b0; wr_i[s] = 1'b0;
        rdy_cyc[s] = cyc;

        e = sbq.pop_front();
        total++;
        if (rdy[s] !== 1'b1 || n != waits(s) + 1) begin
            bad++;
            $display("FAIL latency s%0d a=%h: got %0d cycles (ready=%b) want %0d", s, a, n, rdy[s], waits(s) + 1);
        end
        total++;
        if (err[s] !== e.err) begin
            bad++;
            $display("FAIL mem_err s%0d a=%h: got %b want %b", s, a, err[s], e.err);
        end
        if (e.chk) begin
            total++;
            if (rdat[s] !== e.data) begin
                bad++;
                $display("FAIL rd_data s%0d a=%h: got %h want %h", s, a, rdat[s], e.data);
            end
        end
        @(negedge clock);
        total++;
        if (rdy[s] !== 1'b0) begin
            bad++;
            $display("FAIL ready_pulse s%0d a=%h: got %b want 0", s, a, rdy[s]);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            rd_i[s] = 1'b0; wr_i[s] = 1'b0; addr_i[s] = '0; wd_i[s] = '0;
            exp_rd[s] = '0; exp_rd_v[s] = 1'b1;
            for (int i = 0; i < 256; i++) mdl_v[s][i] = 1'b0;
        end
        repeat (2) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            total++;
            if (rdy[s] !== 1'b0 || err[s] !== 1'b0 || rdat[s] !== 32'h0) begin
                bad++;
                $display("FAIL reset s%0d: got rdy=%b err=%b rd=%h want 0 0 0", s, rdy[s], err[s], rdat[s]);
            end
        end
        Reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_store_load();
        xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 0);
    endtask

    task automatic test_hold();
        xact(0, 1'b0, 1'b1, 32'h14, 32'h5555AAAA, 0);
        repeat (3) @(negedge clock);
        total++;
        if (rdat[0] !== exp_rd[0]) begin
            bad++;
            $display("FAIL idle_hold: got %h want %h", rdat[0], exp_rd[0]);
        end
    endtask

    task automatic test_errors();
        xact(0, 1'b0, 1'b1, 32'h0,   32'hCAFE0000, 0);
        xact(0, 1'b0, 1'b1, 32'h20,  32'hA5A5A5A5, 0);
        xact(0, 1'b1, 1'b0, 32'h20,  32'h0, 0);
        xact(0, 1'b1, 1'b1, 32'h20,  32'hFFFF0000, 0);
        xact(0, 1'b1, 1'b0, 32'h20,  32'h0, 0);
        xact(0, 1'b0, 1'b1, 32'h400, 32'h77777777, 0);
        xact(0, 1'b1, 1'b0, 32'h400, 32'h0, 0);
        xact(0, 1'b1, 1'b0, 32'h0,   32'h0, 0);
        xact(0, 1'b0, 1'b1, 32'h3FC, 32'h0BADF00D, 0);
        xact(0, 1'b1, 1'b0, 32'h3FC, 32'h0, 0);
    endtask

    task automatic test_align();
        xact(0, 1'b1, 1'b0, 32'h13, 32'h0, 0);
    endtask

    task automatic test_drop();
        xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            total++;
            if (rdy[0] !== 1'b0) begin
                bad++;
                $display("FAIL drop_extra_ready cycle %0d: got %b want 0", i, rdy[0]);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        xact(0, 1'b0, 1'b1, 32'h8, 32'h0, 0);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 0);
        rd_i[0] = 1'b0; wr_i[0] = 1'b1; addr_i[0] = 32'h8; wd_i[0] = 32'h12345678;
        @(negedge clock);
        Reset = 1'b0;
        #1;
        total++;
        if (rdy[0] !== 1'b0 || err[0] !== 1'b0 || rdat[0] !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: got rdy=%b err=%b rd=%h want 0 0 0", rdy[0], err[0], rdat[0]);
        end
        wr_i[0] = 1'b0;
        @(negedge clock);
        Reset = 1'b1;
        for (int s = 0; s < 2; s++) begin exp_rd[s] = '0; exp_rd_v[s] = 1'b1; end
        xact(0, 1'b1, 1'b0, 32'h8, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        int c0;
        xact(1, 1'b0, 1'b1, 32'h0, 32'h11111111, 0);
        xact(1, 1'b0, 1'b1, 32'h4, 32'h22222222, 0);
        xact(1, 1'b1, 1'b0, 32'h0, 32'h0, 0);
        c0 = rdy_cyc[1];
        xact(1, 1'b1, 1'b0, 32'h4, 32'h0, 0);
        total++;
        if (rdy_cyc[1] - c0 != 2) begin
            bad++;
            $display("FAIL b2b_period: got %0d cycles want 2", rdy_cyc[1] - c0);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_hold();
        test_errors();
        test_align();
        test_drop();
        test_reset_mid_store();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory target that answers the load/store port driven by the single-cycle MIPS datapath (`mem_rd`, `mem_wr`, `addr`, `wr_data`, `rd_data`). It adds a ready/error handshake and a programmable wait-state counter so the datapath can be tested against slow memory. It sits between the datapath's ALU-address/T-register outputs and the MemToReg mux input, and replaces the zero-latency data memory when stall support is built.

## Interface

Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two.
- `WAIT_CYCLES`, 2: extra cycles between request acceptance and response; legal range 0–15.

Ports:
- `clock`  in  1: single clock, rising edge.
- `Reset`  in  1: asynchronous, active-low.
- `mem_rd`  in  1: load request; held high until `mem_ready`.
- `mem_wr`  in  1: store request; held high until `mem_ready`.
- `addr`  in  32: byte address; stable while a request is high.
- `wr_data`  in  32: store data; stable while `mem_wr` is high.
- `rd_data`  out  32: load result, registered.
- `mem_ready`  out  1: one-cycle response strobe.
- `mem_err`  out  1: qualifies `mem_ready`; the access was rejected.

## Operation

- States: IDLE, WAIT, RESP. Reset forces IDLE.
- IDLE: if `mem_rd | mem_wr`, latch op, `addr`, and `wr_data`, and load `cnt = WAIT_CYCLES`.
  - `WAIT_CYCLES == 0`: go directly to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement `cnt` each edge. On the edge where `cnt == 1`, go to RESP.
- Access happens on the edge entering RESP, using the latched values.
  - Store: `mem[idx] <= wdata`.
  - Load: `rd_data <= mem[idx]`.
  - `idx = addr[$clog2(DEPTH)+1:2]`.
- RESP: `mem_ready = 1` for exactly one cycle, then IDLE.
- Back-to-back: a request present in the cycle after RESP is accepted normally.
- Error cases. Each gives `mem_err = 1` with `mem_ready`, no memory change, and `rd_data` forced to 0:
  - `mem_rd & mem_wr` both high at acceptance.
  - `addr >= DEPTH*4` (out of range).
  - Misalignment, when enabled; see Configuration.
- `rd_data` holds its value across stores and idle cycles. It changes only on a completed load or an error.
- Memory array is not reset. Contents are undefined until written.
- Request inputs are ignored outside IDLE. Deasserting them mid-request does not cancel it.

## Timing

- Request first high in cycle n, with the FSM in IDLE: `mem_ready` is high in cycle n+WAIT_CYCLES+1. Total latency is WAIT_CYCLES+1 cycles.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- `rd_data` is valid in the same cycle as `mem_ready` and stays valid afterwards.
- Reset values: `rd_data = 0`, `mem_ready = 0`, `mem_err = 0`, state IDLE, `cnt = 0`.
- Reset asserted mid-request: abort immediately. A store whose RESP-entry edge has not occurred does not write.
- Reset deasserted: the first acceptance happens on the first rising edge with a request present.

## Configuration

- `DMEM_ALIGN_CHECK_EN` defined: `addr[1:0] != 0` at acceptance is an error response; no access.
- `DMEM_ALIGN_CHECK_EN` undefined: `addr[1:0]` is ignored and the access uses the word index. `mem_err` only reflects the collision and range errors.

## Structure

- Package `dmem_pkg` holds:
  - State enum `dmem_state_t` (IDLE, WAIT, RESP).
  - Op encoding `dmem_op_t` (OP_RD, OP_WR, OP_BAD).
  - Constant `DMEM_CNT_W = 4`.
- One sub-module, `dmem_wait_counter`: loadable down-counter with a `done` output (`cnt == 1`, or load value 0). Everything else lives in `dmem_responder`.

## Test plan

- Store then load, WAIT_CYCLES=2: `mem_wr`, `addr=0x10`, `wr_data=0xDEADBEEF` → `mem_ready` 3 cycles later, `mem_err=0`. Then `mem_rd addr=0x10` → `rd_data=0xDEADBEEF` with `mem_ready`.
- Zero wait, WAIT_CYCLES=0: back-to-back loads of `0x0` and `0x4` → a `mem_ready` pulse every 2 cycles, with the correct data on each.
- Errors:
  - `mem_rd & mem_wr` both high at `addr=0x20` → `mem_err=1`, `rd_data=0`, and a later load of `0x20` returns the prior value.
  - `addr=0x400` with DEPTH=256 → `mem_err=1`.
- Alignment: `mem_rd addr=0x13`.
  - With `DMEM_ALIGN_CHECK_EN`: `mem_err=1`.
  - Without it: returns word `0x10`.
- Reset mid-store: assert `Reset=0` during WAIT of a store of `0x12345678` to `0x8` → outputs go to 0 asynchronously, and a later load of `0x8` does not return `0x12345678` (word pre-written with `0x0`).
- Hold behaviour: a store after a load leaves `rd_data` unchanged. `mem_rd` dropped during WAIT still yields one `mem_ready` pulse.
